program_loader: RTL
===================

# program_loader

Upstream feeder for the RV32I core's Harvard program memory. It receives a byte stream with a valid/ready handshake, for example from a UART receiver. It parses a framed program image, writes each 32-bit instruction word into program memory, and holds the core in reset with the program-mode line asserted until a complete, checksum-verified image has been loaded. On success it releases the core to fetch from word address 0. On any framing or checksum error it latches an error code and keeps the core in reset.

## Interface
Parameters:
- INSTR_ADDR_WIDTH, 8, word address width of program memory; capacity is 2^INSTR_ADDR_WIDTH words.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  a byte is present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- pgm  out  1  program-mode flag for program memory; high while loading.
- pgm_we  out  1  one-cycle write strobe for program memory.
- pgm_addr  out  INSTR_ADDR_WIDTH  word address to write.
- pgm_data  out  32  instruction word to write.
- core_rst  out  1  reset request for the core; high unless the loader is in DONE.
- done  out  1  image loaded and verified.
- err  out  2  error code: 00 none, 01 length overflow, 10 checksum mismatch.

## Operation
- Frame format, little-endian throughout:
  - MAGIC.
  - LEN_LO, LEN_HI: 16-bit word count N.
  - N words, each sent as 4 bytes, LSB first.
  - CKSUM: XOR of LEN_LO, LEN_HI and every data byte.
- A byte is accepted on any posedge where in_valid && in_ready.
- States and transitions:
  - IDLE: waits for MAGIC. A non-MAGIC byte is discarded and the state stays IDLE (resynchronisation). MAGIC → LEN0.
  - LEN0: stores LEN_LO → LEN1.
  - LEN1: stores LEN_HI.
    - N > 2^INSTR_ADDR_WIDTH → ERR with err=01.
    - N == 0 → CKSUM.
    - Otherwise → DATA.
  - DATA: shifts bytes into a 32-bit assembly register.
    - On the 4th byte of a word, issues a write to pgm_addr and then increments pgm_addr.
    - After word N → CKSUM.
  - CKSUM: compares the byte with the running XOR.
    - Equal → DONE.
    - Otherwise → ERR with err=10.
  - DONE: terminal until rst. Drives pgm=0, core_rst=0, done=1.
  - ERR: terminal until rst. Drives pgm=1, core_rst=1 and keeps err latched.
- in_ready: 1 in IDLE, LEN0, LEN1, DATA and CKSUM; 0 in DONE and ERR.
- Running XOR: cleared on MAGIC acceptance; updated with every accepted LEN and data byte.
- Byte counter: 2-bit, wraps 3→0 at each word boundary.
- Word counter: 16-bit; compared to N.
- pgm_addr width rule: a full memory (N = 2^INSTR_ADDR_WIDTH) makes the last word land at the all-ones address. pgm_addr then wraps to 0, and that wrap is legal.
- MAGIC bytes seen inside LEN, DATA or CKSUM are payload, not a restart.
- in_valid held low: the FSM stalls in place with no timeout.

## Timing
- Reset values: state=IDLE, in_ready=1, pgm=1, pgm_we=0, pgm_addr=0, pgm_data=0, core_rst=1, done=0, err=00. Byte counter, word counter, length register and XOR register are all 0.
- pgm_we is registered:
  - It is high for exactly one cycle, the cycle after the edge that accepts a word's 4th byte.
  - pgm_data and pgm_addr are valid and stable while pgm_we is high.
  - pgm_addr increments on the edge that ends the strobe.
- Back-to-back bytes every cycle are supported. The minimum spacing between pgm_we pulses is 4 cycles.
- The cycle after the CKSUM byte is accepted, done, pgm and core_rst reflect DONE (or ERR). The core sees core_rst fall on that cycle and fetches address 0 on the next cycle.
- rst mid-load: on the next edge all state returns to reset values and any partial word is dropped. Memory contents already written remain; no write strobe is issued during or after rst.
- rst while in DONE: returns to IDLE, reasserts pgm and core_rst, and a reload is required.

## Test plan
- Nominal load: A5 02 00 13 00 00 00 93 00 10 00 92 streamed one byte per cycle.
  - Required: writes 0x00000013 @0, then 0x00100093 @1.
  - Required: done=1, core_rst=0, err=00.
- Checksum error: the same stream with final byte 0x93.
  - Required: both writes occur, then ERR with err=10.
  - Required: core_rst=1, in_ready=0, and these hold until rst.
- Resync and gaps: leading 00 FF 13 before A5 and a frame with N=0 (A5 00 00 00), with in_valid gaps between bytes.
  - Required: leading bytes ignored and no pgm_we.
  - Required: DONE reached; stalls do not alter the result.
- Length overflow: INSTR_ADDR_WIDTH=8, frame A5 01 01 (N=257).
  - Required: ERR with err=01 immediately after LEN_HI and no writes.
  - With N=256, required: the last write goes to address 0xFF and DONE is reached.
- Reset mid-word: rst pulsed after 2 data bytes of word 1, then a full nominal frame.
  - Required: no stray write; the new frame writes from address 0 and reaches DONE.
- Payload MAGIC: a word 0x000000A5 inside the frame.
  - Required: written intact to memory and no restart of the frame.

Source files
------------

// File: rtl/program_loader.sv
// Framed program-image loader for the RV32I program memory.
// Holds the core in reset until a checksum-verified image is written.
module program_loader #(
  parameter int         INSTR_ADDR_WIDTH = 8,
  parameter logic [7:0] MAGIC            = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        pgm,
  output logic                        pgm_we,
  output logic [INSTR_ADDR_WIDTH-1:0] pgm_addr,
  output logic [31:0]                 pgm_data,
  output logic                        core_rst,
  output logic                        done,
  output logic [1:0]                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CAP =
    17'(1) << INSTR_ADDR_WIDTH;
  localparam logic [INSTR_ADDR_WIDTH-1:0] ADDR_ONE =
    INSTR_ADDR_WIDTH'(1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] len;
  logic [7:0]  xsum;
  logic [23:0] asm_q;

  logic        accept;
  logic [15:0] n_len;
  logic [31:0] word;
  logic [15:0] word_nxt;

  assign accept   = in_valid && in_ready;
  assign n_len    = {in_data, len[7:0]};
  assign word     = {in_data, asm_q};
  assign word_nxt = word_cnt + 16'd1;

  // Frame parser, word assembly, write strobe and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      word_cnt <= 16'd0;
      len      <= 16'd0;
      xsum     <= 8'd0;
      asm_q    <= 24'd0;
      in_ready <= 1'b1;
      pgm      <= 1'b1;
      pgm_we   <= 1'b0;
      pgm_addr <= '0;
      pgm_data <= 32'd0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 2'b00;
    end else begin
      pgm_we <= 1'b0;
      if (pgm_we)
        pgm_addr <= pgm_addr + ADDR_ONE;
      if (accept) begin
        unique case (state)
          S_IDLE: begin
            if (in_data == MAGIC) begin
              state <= S_LEN0;
              xsum  <= 8'd0;
            end
          end
          S_LEN0: begin
            len[7:0] <= in_data;
            xsum     <= xsum ^ in_data;
            state    <= S_LEN1;
          end
          S_LEN1: begin
            len[15:8] <= in_data;
            xsum      <= xsum ^ in_data;
            if ({1'b0, n_len} > CAP) begin
              state    <= S_ERR;
              err      <= 2'b01;
              in_ready <= 1'b0;
            end else if (n_len == 16'd0) begin
              state <= S_CKSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            xsum     <= xsum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              pgm_we   <= 1'b1;
              pgm_data <= word;
              word_cnt <= word_nxt;
              if (word_nxt == len)
                state <= S_CKSUM;
            end else begin
              asm_q <= {in_data, asm_q[23:8]};
            end
          end
          S_CKSUM: begin
            in_ready <= 1'b0;
            if (in_data == xsum) begin
              state    <= S_DONE;
              pgm      <= 1'b0;
              core_rst <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 2'b10;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
